// File: rtl/hub75_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scanner_pkg
// Purpose  : Shared HUB75 timing constants, scanner state encoding and pixel
//            field layout. The pattern and dimmer stages use the same layout.
// Contents : COLS, SCAN_ROWS, BITS, BASE_TICKS, counter widths,
//            scan_state_t, pixel field offsets, plane_bits(), plane_ticks()
// Revision : 1.0  initial release
// ============================================================================
package hub75_scanner_pkg;

    // Panel geometry and modulation depth
    localparam int COLS       = 32;
    localparam int SCAN_ROWS  = 16;
    localparam int BITS       = 8;
    localparam int BASE_TICKS = 4;

    // Counter and bus widths
    localparam int COL_W    = 5;
    localparam int ROW_W    = 4;
    localparam int PLANE_W  = 3;
    localparam int PHASE_W  = 2;
    localparam int ADDR_W   = 11;
    localparam int PIXEL_W  = 24;
    localparam int CHAN_W   = 8;

    // Wide enough to hold the longest plane (BASE_TICKS << (BITS-1))
    localparam int TICK_W = $clog2(BASE_TICKS << (BITS - 1)) + 1;

    // Pixel word layout {blue, green, red}
    localparam int RED_LSB   = 0;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 16;

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_BLANK   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_DISPLAY = 2'd3
    } scan_state_t;

    // Selected bit plane of each channel, returned as {blue, green, red}
    function automatic logic [2:0] plane_bits(input logic [PIXEL_W-1:0] pixel,
                                              input logic [PLANE_W-1:0] plane);
        logic [CHAN_W-1:0] red;
        logic [CHAN_W-1:0] green;
        logic [CHAN_W-1:0] blue;
        red   = pixel[RED_LSB   +: CHAN_W];
        green = pixel[GREEN_LSB +: CHAN_W];
        blue  = pixel[BLUE_LSB  +: CHAN_W];
        return {blue[plane], green[plane], red[plane]};
    endfunction

    // Display time of one bit plane in clk cycles
    function automatic logic [TICK_W-1:0] plane_ticks(input logic [PLANE_W-1:0] plane);
        return TICK_W'(BASE_TICKS) << plane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_scanner_bcm_timer.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scanner_bcm_timer
// Purpose  : Bit-plane on-time counter. Loads BASE_TICKS << plane, counts
//            down and flags the final cycle of the display window.
// Ports    : clk   in  clock
//            rst   in  asynchronous reset, active-high
//            load  in  load the count for the given plane
//            plane in  bit plane being displayed
//            done  out high during the last cycle of the window
// Revision : 1.0  initial release
// ============================================================================
module hub75_scanner_bcm_timer
    import hub75_scanner_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    output logic               done
);

    logic [TICK_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= plane_ticks(plane);
        end else if (r_count != '0) begin
            r_count <= r_count - TICK_W'(1);
        end
    end

    // Loaded on the cycle before the window opens, so count==1 marks the
    // last of exactly plane_ticks(plane) cycles.
    assign done = (r_count == TICK_W'(1));

endmodule
`default_nettype wire

// File: rtl/hub75_scanner.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scanner
// Purpose  : Reads the displayed frame buffer and drives a 32x32, 1/16-scan
//            HUB75 panel with binary code modulation (8 bits per colour).
//            Adopts the writer's buffer selection only at frame boundaries.
// Ports    : clk, rst               clock, asynchronous active-high reset
//            selected_buffer  in    buffer the writer wants shown next
//            actual_buffer    out   buffer currently shown
//            rd_addr          out   {buffer, row[4:0], col[4:0]}
//            rd_data          in    {B,G,R} pixel, one clk after rd_addr
//            r1,g1,b1         out   upper-half colour bits
//            r2,g2,b2         out   lower-half colour bits
//            panel_clk        out   shift clock (panel samples on rise)
//            lat              out   latch strobe
//            oe_n             out   output enable, active-low
//            a                out   row-select address
// Revision : 1.0  initial release
// ============================================================================
module hub75_scanner
    import hub75_scanner_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               selected_buffer,
    output logic               actual_buffer,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIXEL_W-1:0] rd_data,
    output logic               r1,
    output logic               g1,
    output logic               b1,
    output logic               r2,
    output logic               g2,
    output logic               b2,
    output logic               panel_clk,
    output logic               lat,
    output logic               oe_n,
    output logic [ROW_W-1:0]   a
);

    scan_state_t         r_state;
    logic [PHASE_W-1:0]  r_phase;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [PLANE_W-1:0]  r_plane;
    logic [PIXEL_W-1:0]  r_upper;
    logic                r_actual_buffer;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [2:0]          r_rgb1;   // {b1, g1, r1}
    logic [2:0]          r_rgb2;   // {b2, g2, r2}
    logic                r_panel_clk;
    logic                r_lat;
    logic                r_oe_n;
    logic [ROW_W-1:0]    r_a;

    logic                w_timer_load;
    logic                w_timer_done;
    logic                w_last_plane;
    logic                w_frame_end;
    logic [ROW_W-1:0]    w_next_row;
    logic                w_next_buffer;

    assign w_timer_load  = (r_state == ST_LATCH);
    assign w_last_plane  = (r_plane == PLANE_W'(BITS - 1));
    assign w_frame_end   = w_last_plane && (r_row == ROW_W'(SCAN_ROWS - 1));
    assign w_next_row    = w_last_plane ? r_row + ROW_W'(1) : r_row;
    // The writer's choice is only sampled as the last pass of a frame ends
    assign w_next_buffer = w_frame_end ? selected_buffer : r_actual_buffer;

    hub75_scanner_bcm_timer u_bcm_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_timer_load),
        .plane (r_plane),
        .done  (w_timer_done)
    );

    // Read pipeline per column (4 cycles, memory latency 1 clk):
    //   the upper address is already on rd_addr when phase 0 starts;
    //   phase 0 issues the lower address, phase 1 captures the upper pixel,
    //   phase 2 drives both halves' colour bits (lower straight from rd_data),
    //   phase 3 raises panel_clk. The colour bits stay put until the next
    //   column's phase 2, so they are stable across the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_SHIFT;
            r_phase         <= '0;
            r_col           <= '0;
            r_row           <= '0;
            r_plane         <= '0;
            r_upper         <= '0;
            r_actual_buffer <= 1'b0;
            r_rd_addr       <= '0;
            r_rgb1          <= '0;
            r_rgb2          <= '0;
            r_panel_clk     <= 1'b0;
            r_lat           <= 1'b0;
            r_oe_n          <= 1'b1;
            r_a             <= '0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    case (r_phase)
                        2'd0: begin
                            r_rd_addr   <= {r_actual_buffer, 1'b1, r_row, r_col};
                            r_panel_clk <= 1'b0;
                        end
                        2'd1: begin
                            r_upper <= rd_data;
                        end
                        2'd2: begin
                            r_rgb1 <= plane_bits(r_upper, r_plane);
                            r_rgb2 <= plane_bits(rd_data, r_plane);
                        end
                        default: begin
                            r_panel_clk <= 1'b1;
                            r_col       <= r_col + COL_W'(1);
                            if (r_col == COL_W'(COLS - 1)) begin
                                r_state <= ST_BLANK;
                            end else begin
                                r_rd_addr <= {r_actual_buffer, 1'b0, r_row, r_col + COL_W'(1)};
                            end
                        end
                    endcase
                    r_phase <= r_phase + PHASE_W'(1);
                end

                ST_BLANK: begin
                    // Last rising edge of the shift is visible this cycle
                    r_panel_clk <= 1'b0;
                    r_a         <= r_row;
                    r_lat       <= 1'b1;
                    r_state     <= ST_LATCH;
                end

                ST_LATCH: begin
                    r_lat   <= 1'b0;
                    r_oe_n  <= 1'b0;
                    r_state <= ST_DISPLAY;
                end

                ST_DISPLAY: begin
                    if (w_timer_done) begin
                        r_oe_n          <= 1'b1;
                        r_plane         <= r_plane + PLANE_W'(1);
                        r_row           <= w_next_row;
                        r_actual_buffer <= w_next_buffer;
                        // Prime the first upper-half address of the next pass
                        r_rd_addr       <= {w_next_buffer, 1'b0, w_next_row, COL_W'(0)};
                        r_state         <= ST_SHIFT;
                    end
                end
            endcase
        end
    end

    assign actual_buffer = r_actual_buffer;
    assign rd_addr       = r_rd_addr;
    assign r1            = r_rgb1[0];
    assign g1            = r_rgb1[1];
    assign b1            = r_rgb1[2];
    assign r2            = r_rgb2[0];
    assign g2            = r_rgb2[1];
    assign b2            = r_rgb2[2];
    assign panel_clk     = r_panel_clk;
    assign lat           = r_lat;
    assign oe_n          = r_oe_n;
    assign a             = r_a;

endmodule
`default_nettype wire

// File: tb/tb_hub75_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_scanner
// Purpose  : Self-checking bench for hub75_scanner. A random frame memory with
//            a 1-clk read is attached; expected panel activity is derived from
//            the pass schedule (130 + 4<<plane cycles per row/plane pass).
// Revision : 1.0  initial release
// ============================================================================
module tb_hub75_scanner;

    localparam int BASE     = 4;
    localparam int SHIFT_CY = 128;
    localparam int FRAME_CY = 16 * (8 * (SHIFT_CY + 2) + BASE * 255);

    logic        clk;
    logic        rst;
    logic        selected_buffer;
    logic        actual_buffer;
    logic [10:0] rd_addr;
    logic [23:0] rd_data;
    logic        r1, g1, b1, r2, g2, b2;
    logic        panel_clk;
    logic        lat;
    logic        oe_n;
    logic [3:0]  a;

    logic [23:0] mem [0:2047];

    int n_checks;
    int n_pass;
    int cyc;
    int frame_lat [2];
    logic prev_pclk;
    logic writer_on;

    hub75_scanner dut (
        .clk             (clk),
        .rst             (rst),
        .selected_buffer (selected_buffer),
        .actual_buffer   (actual_buffer),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .r1              (r1),
        .g1              (g1),
        .b1              (b1),
        .r2              (r2),
        .g2              (g2),
        .b2              (b2),
        .panel_clk       (panel_clk),
        .lat             (lat),
        .oe_n            (oe_n),
        .a               (a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous frame memory: data for an address appears one clk later
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // {blue, green, red} bit of the given plane
    function automatic logic [2:0] exp_bits(input logic [23:0] pix, input int plane);
        logic [23:0] s;
        s = pix >> plane;
        return {s[16], s[8], s[0]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_stim();
        if (writer_on) begin
            // Writer finishes a buffer whenever the scanner has caught up
            if (actual_buffer === selected_buffer) selected_buffer = ~selected_buffer;
        end else if (cyc == 1000) begin
            selected_buffer = 1'b1;
        end else if (cyc == 2000) begin
            selected_buffer = 1'b0;
        end else if (cyc == 20000) begin
            selected_buffer = 1'b1;
        end
    endtask

    // Observe one (row, plane) pass; trunc_len > 0 stops early inside DISPLAY
    task automatic run_pass(input int frame, input int row, input int plane,
                            input logic buf_sel, input int trunc_len);
        int len, exp_low;
        int rises, lats, lat_off, oe_low, oe_bad, a_bad, buf_bad, col_bad;
        logic [10:0] ua, la;
        len     = (trunc_len > 0) ? trunc_len : SHIFT_CY + 2 + (BASE << plane);
        exp_low = len - (SHIFT_CY + 2);
        rises = 0; lats = 0; lat_off = -1; oe_low = 0;
        oe_bad = 0; a_bad = 0; buf_bad = 0; col_bad = 0;
        for (int o = 0; o < len; o++) begin
            if (panel_clk === 1'b1 && prev_pclk === 1'b0) begin
                if (rises < 32) begin
                    ua = {buf_sel, 1'b0, row[3:0], rises[4:0]};
                    la = {buf_sel, 1'b1, row[3:0], rises[4:0]};
                    if ({b1, g1, r1} !== exp_bits(mem[ua], plane) ||
                        {b2, g2, r2} !== exp_bits(mem[la], plane)) col_bad++;
                end
                rises++;
            end
            prev_pclk = panel_clk;
            if (lat === 1'b1) begin
                lats++;
                lat_off = o;
                if (row == 0 && plane == 0) frame_lat[frame] = cyc;
            end
            if (oe_n === 1'b0) oe_low++;
            if (oe_n !== ((o >= SHIFT_CY + 2) ? 1'b0 : 1'b1)) oe_bad++;
            if (o >= SHIFT_CY + 2 && a !== row[3:0]) a_bad++;
            if (rd_addr[10] !== buf_sel || actual_buffer !== buf_sel) buf_bad++;
            drive_stim();
            next_cycle();
        end
        check($sformatf("rises f%0d r%0d p%0d", frame, row, plane), rises, 32);
        check($sformatf("colour f%0d r%0d p%0d", frame, row, plane), col_bad, 0);
        check($sformatf("lat_count f%0d r%0d p%0d", frame, row, plane), lats, 1);
        check($sformatf("lat_pos f%0d r%0d p%0d", frame, row, plane), lat_off, SHIFT_CY + 1);
        check($sformatf("oe_low f%0d r%0d p%0d", frame, row, plane), oe_low, exp_low);
        check($sformatf("oe_window f%0d r%0d p%0d", frame, row, plane), oe_bad, 0);
        check($sformatf("row_addr f%0d r%0d p%0d", frame, row, plane), a_bad, 0);
        check($sformatf("buffer f%0d r%0d p%0d", frame, row, plane), buf_bad, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        frame_lat = '{-1, -1};
        prev_pclk = 1'b0;
        writer_on = 1'b0;
        rst       = 1'b1;
        selected_buffer = 1'b0;

        for (int i = 0; i < 2048; i++) mem[i] = 24'($urandom);
        // Buffer 0: row 0 pure red, row 16 pure blue
        for (int c = 0; c < 32; c++) begin
            mem[c]       = 24'h0000FF;
            mem[512 + c] = 24'hFF0000;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset rd_addr", rd_addr, 0);
        check("reset colours", {r1, g1, b1, r2, g2, b2}, 0);
        check("reset panel_clk", panel_clk, 0);
        check("reset lat", lat, 0);
        check("reset oe_n", oe_n, 1);
        check("reset a", a, 0);
        check("reset actual_buffer", actual_buffer, 0);
        rst = 1'b0;

        // Frame 0 on buffer 0; selection toggles 1 -> 0 -> 1 mid-frame
        for (int r = 0; r < 16; r++)
            for (int p = 0; p < 8; p++)
                run_pass(0, r, p, 1'b0, 0);

        // Frame 1 on buffer 1 with the handshaking writer attached
        writer_on = 1'b1;
        for (int p = 0; p < 7; p++) run_pass(1, 0, p, 1'b1, 0);
        run_pass(1, 0, 7, 1'b1, SHIFT_CY + 2 + 100);

        check("frame0 first lat cycle", frame_lat[0], SHIFT_CY + 1);
        check("frame length", frame_lat[1] - frame_lat[0], FRAME_CY);

        // Asynchronous reset in the middle of a DISPLAY window
        #2;
        rst = 1'b1;
        #1;
        check("midreset oe_n", oe_n, 1);
        check("midreset lat", lat, 0);
        check("midreset panel_clk", panel_clk, 0);
        check("midreset actual_buffer", actual_buffer, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post-reset rd_addr 0", rd_addr, 11'h000);
        next_cycle();
        check("post-reset rd_addr 1", rd_addr, 11'h200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
